// File: rtl/rbm_pkg.sv
// rbm_pkg: default RBM dimensions, sequencer state encoding and
// width/slice helper macros shared by the sequencer files.
`ifndef RBM_PKG_SV
`define RBM_PKG_SV

`define RBM_CW(n) (((n) > 1) ? $clog2(n) : 1)
`define RBM_CNT_SL(k, w) ((k) * (w)) +: (w)

package rbm_pkg;

    localparam int unsigned RBM_N_PIXEL   = 784;
    localparam int unsigned RBM_N_HIDDEN  = 441;
    localparam int unsigned RBM_N_CLASS   = 10;
    localparam int unsigned RBM_W_WIDTH   = 12;
    localparam int unsigned RBM_N_ITER    = 2;
    localparam int unsigned RBM_CNT_WIDTH = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREFETCH = 3'd1;
    localparam logic [2:0] ST_H_STREAM = 3'd2;
    localparam logic [2:0] ST_C_STREAM = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_PREFETCH = ST_PREFETCH,
        S_H_STREAM = ST_H_STREAM,
        S_C_STREAM = ST_C_STREAM,
        S_DONE     = ST_DONE
    } rbm_state_t;

endpackage

`endif

// File: rtl/rbm_sequencer_beat_counter.sv
// rbm_beat_counter: nested outer/inner beat counter with last flags,
// one instance per streaming phase of the sequencer.
module rbm_beat_counter #(
    parameter int unsigned OUTER_N = 2,
    parameter int unsigned INNER_N = 2,
    parameter int unsigned OW      = 1,
    parameter int unsigned IW      = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_clr,
    input  logic          i_adv,
    output logic [OW-1:0] o_outer,
    output logic [IW-1:0] o_inner,
    output logic          o_inner_last,
    output logic          o_last
);

    localparam logic [OW-1:0] O_MAX = OW'(OUTER_N - 1);
    localparam logic [IW-1:0] I_MAX = IW'(INNER_N - 1);

    logic [OW-1:0] r_outer;
    logic [IW-1:0] r_inner;

    assign o_outer      = r_outer;
    assign o_inner      = r_inner;
    assign o_inner_last = (r_inner == I_MAX);
    assign o_last       = o_inner_last && (r_outer == O_MAX);

    // Wraps to zero after the final beat so the next phase starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outer <= '0;
            r_inner <= '0;
        end else if (i_clr) begin
            r_outer <= '0;
            r_inner <= '0;
        end else if (i_adv) begin
            if (o_inner_last) begin
                r_inner <= '0;
                r_outer <= o_last ? '0 : r_outer + 1'b1;
            end else begin
                r_inner <= r_inner + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rbm_sequencer.sv
// rbm_sequencer: streams image/weight ROMs into the Main RBM datapath,
// captures hidden results and accumulates per-class spike counts.
module rbm_sequencer
    import rbm_pkg::*;
#(
    parameter int unsigned N_PIXEL   = RBM_N_PIXEL,
    parameter int unsigned N_HIDDEN  = RBM_N_HIDDEN,
    parameter int unsigned N_CLASS   = RBM_N_CLASS,
    parameter int unsigned W_WIDTH   = RBM_W_WIDTH,
    parameter int unsigned N_ITER    = RBM_N_ITER,
    parameter int unsigned CNT_WIDTH = RBM_CNT_WIDTH
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic [`RBM_CW(N_PIXEL)-1:0]        img_addr,
    input  logic                               img_bit,
    output logic [`RBM_CW(N_PIXEL+1)-1:0]      h_row,
    output logic [`RBM_CW(N_HIDDEN)-1:0]       h_col,
    input  logic [W_WIDTH-1:0]                 h_data,
    output logic [`RBM_CW(N_HIDDEN)-1:0]       sw_addr,
    input  logic                               sw_bit,
    output logic [`RBM_CW(N_HIDDEN+1)-1:0]     c_row,
    output logic [`RBM_CW(N_CLASS)-1:0]        c_col,
    input  logic [W_WIDTH-1:0]                 c_data,
    output logic [`RBM_CW(N_PIXEL+1)-1:0]      pixel_id,
    output logic                               pixel,
    output logic [W_WIDTH-1:0]                 Hvalue,
    output logic                               HiddenSwitch,
    output logic                               enable_hidden,
    output logic                               enable_classi,
    output logic [W_WIDTH-1:0]                 Cvalue,
    output logic [`RBM_CW(N_HIDDEN+1)-1:0]     hidden_id,
    output logic                               hidden_pixel,
    input  logic                               hidden,
    input  logic                               spike,
    output logic [N_CLASS*CNT_WIDTH-1:0]       counts
);

    localparam int unsigned IMG_W = `RBM_CW(N_PIXEL);
    localparam int unsigned HR_W  = `RBM_CW(N_PIXEL+1);
    localparam int unsigned HC_W  = `RBM_CW(N_HIDDEN);
    localparam int unsigned CR_W  = `RBM_CW(N_HIDDEN+1);
    localparam int unsigned CC_W  = `RBM_CW(N_CLASS);
    localparam int unsigned IT_W  = `RBM_CW(N_ITER);

    rbm_state_t r_state;
    logic       r_busy;
    logic       r_done;

    logic            r_iss_act;
    logic            r_iss_c;
    logic [IT_W-1:0] r_iter;

    logic            r_p_en_h;
    logic            r_p_en_c;
    logic            r_p_hbias;
    logic            r_p_cbias;
    logic [HR_W-1:0] r_p_pix;
    logic [CR_W-1:0] r_p_hid;
    logic [HC_W-1:0] r_p_j;
    logic [HC_W-1:0] r_p_i;
    logic [CC_W-1:0] r_p_k;

    logic            r_cap_v;
    logic [HC_W-1:0] r_cap_j;
    logic            r_sp_v;
    logic [CC_W-1:0] r_sp_k;

    logic [N_HIDDEN-1:0]          r_hvec;
    logic [N_CLASS*CNT_WIDTH-1:0] r_cnt;

    logic            w_clr;
    logic            w_h_adv;
    logic            w_c_adv;
    logic [HC_W-1:0] w_h_j;
    logic [HR_W-1:0] w_h_p;
    logic            w_h_plast;
    logic            w_h_last;
    logic [CC_W-1:0] w_c_k;
    logic [CR_W-1:0] w_c_i;
    logic            w_c_ilast;
    logic            w_c_last;
    logic            w_fwd;

    assign w_clr   = (r_state == S_IDLE) && start;
    assign w_h_adv = r_iss_act && !r_iss_c;
    assign w_c_adv = r_iss_act && r_iss_c;

    rbm_beat_counter #(
        .OUTER_N (N_HIDDEN),
        .INNER_N (N_PIXEL + 1),
        .OW      (HC_W),
        .IW      (HR_W)
    ) u_hcnt (
        .clk          (clock),
        .rst_n        (reset),
        .i_clr        (w_clr),
        .i_adv        (w_h_adv),
        .o_outer      (w_h_j),
        .o_inner      (w_h_p),
        .o_inner_last (w_h_plast),
        .o_last       (w_h_last)
    );

    rbm_beat_counter #(
        .OUTER_N (N_CLASS),
        .INNER_N (N_HIDDEN + 1),
        .OW      (CC_W),
        .IW      (CR_W)
    ) u_ccnt (
        .clk          (clock),
        .rst_n        (reset),
        .i_clr        (w_clr),
        .i_adv        (w_c_adv),
        .o_outer      (w_c_k),
        .o_inner      (w_c_i),
        .o_inner_last (w_c_ilast),
        .o_last       (w_c_last)
    );

    // The counters are the issue side: they run one beat ahead of
    // the presented beat to hide the ROM read latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_iss_act <= 1'b0;
            r_iss_c   <= 1'b0;
            r_iter    <= '0;
        end else if (w_clr) begin
            r_iss_act <= 1'b1;
            r_iss_c   <= 1'b0;
            r_iter    <= '0;
        end else if (w_h_adv && w_h_last) begin
            r_iss_c <= 1'b1;
        end else if (w_c_adv && w_c_last) begin
            r_iss_c <= 1'b0;
            if (r_iter == IT_W'(N_ITER - 1)) begin
                r_iss_act <= 1'b0;
                r_iter    <= '0;
            end else begin
                r_iter <= r_iter + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= S_PREFETCH;
                        r_busy  <= 1'b1;
                    end
                end
                S_PREFETCH, S_H_STREAM, S_C_STREAM: begin
                    if (!r_iss_act) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= r_iss_c ? S_C_STREAM : S_H_STREAM;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_p_en_h  <= 1'b0;
            r_p_en_c  <= 1'b0;
            r_p_hbias <= 1'b0;
            r_p_cbias <= 1'b0;
            r_p_pix   <= '0;
            r_p_hid   <= '0;
            r_p_j     <= '0;
            r_p_i     <= '0;
            r_p_k     <= '0;
        end else begin
            r_p_en_h  <= w_h_adv;
            r_p_en_c  <= w_c_adv;
            r_p_hbias <= w_h_adv && w_h_plast;
            r_p_cbias <= w_c_adv && w_c_ilast;
            r_p_pix   <= w_h_adv ? w_h_p : '0;
            r_p_hid   <= w_h_adv ? CR_W'(w_h_j) :
                         w_c_adv ? w_c_i : '0;
            r_p_j     <= w_h_j;
            r_p_i     <= HC_W'(w_c_i);
            r_p_k     <= w_c_k;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cap_v <= 1'b0;
            r_cap_j <= '0;
            r_sp_v  <= 1'b0;
            r_sp_k  <= '0;
            r_hvec  <= '0;
        end else begin
            r_cap_v <= r_p_en_h && r_p_hbias;
            r_cap_j <= r_p_j;
            r_sp_v  <= r_p_en_c && r_p_cbias;
            r_sp_k  <= r_p_k;
            if (r_cap_v) begin
                r_hvec[r_cap_j] <= hidden;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == S_PREFETCH) begin
            r_cnt <= '0;
        end else if (r_sp_v && spike) begin
            for (int k = 0; k < int'(N_CLASS); k++) begin
                if (r_sp_k == CC_W'(k) &&
                    r_cnt[`RBM_CNT_SL(k, CNT_WIDTH)] != '1) begin
                    r_cnt[`RBM_CNT_SL(k, CNT_WIDTH)] <=
                        r_cnt[`RBM_CNT_SL(k, CNT_WIDTH)] + 1'b1;
                end
            end
        end
    end

    // A capture landing on the beat that reads the same neuron
    // has not reached r_hvec yet, so take the live input.
    assign w_fwd = r_cap_v && (r_cap_j == r_p_i);

    assign busy          = r_busy;
    assign done          = r_done;
    assign counts        = r_cnt;
    assign img_addr      = w_h_plast ? '0 : IMG_W'(w_h_p);
    assign h_row         = w_h_p;
    assign h_col         = w_h_j;
    assign sw_addr       = w_h_j;
    assign c_row         = w_c_i;
    assign c_col         = w_c_k;
    assign pixel_id      = r_p_pix;
    assign hidden_id     = r_p_hid;
    assign enable_hidden = r_p_en_h;
    assign enable_classi = r_p_en_c;
    assign pixel         = r_p_en_h && (r_p_hbias || img_bit);
    assign Hvalue        = r_p_en_h ? h_data : '0;
    assign HiddenSwitch  = r_p_en_h && sw_bit;
    assign Cvalue        = r_p_en_c ? c_data : '0;
    assign hidden_pixel  = r_p_en_c &&
                           (r_p_cbias || (w_fwd ? hidden : r_hvec[r_p_i]));

endmodule

// File: tb/tb_rbm_sequencer.sv
// tb_rbm_sequencer: directed checks of the RBM sequencer on small
// dimensions, with simple ROM and Main models driven by the bench.
module tb_rbm_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic rstA, rstBC, startA, startBC;

    // Instance A: 4 pixels, 3 hidden, 2 classes, 1 iteration.
    logic        a_busy, a_done, a_pix, a_sw_o, a_enh, a_enc, a_hpix;
    logic [1:0]  a_img_addr, a_hcol, a_swaddr, a_crow, a_hidid;
    logic [2:0]  a_hrow, a_pid;
    logic [0:0]  a_ccol;
    logic [11:0] a_hval, a_cval;
    logic [15:0] a_counts;
    logic        a_img = 1'b0, a_sw = 1'b0, a_hid_in = 1'b0;
    logic [11:0] a_h = '0, a_c = '0;

    always_ff @(posedge clk) begin
        a_img    <= 1'b1;
        a_h      <= (a_hrow == 3'd4) ? 12'd100 + 12'(a_hcol)
                                     : 12'(a_hrow) * 12'd16 + 12'(a_hcol);
        a_sw     <= (a_swaddr == 2'd1);
        a_c      <= (a_crow == 2'd3) ? 12'd200 + 12'(a_ccol)
                                     : 12'(a_crow) * 12'd8 + 12'(a_ccol);
        a_hid_in <= a_enh && (a_pid == 3'd4) && (a_hidid == 2'd1);
    end

    rbm_sequencer #(
        .N_PIXEL(4), .N_HIDDEN(3), .N_CLASS(2),
        .W_WIDTH(12), .N_ITER(1), .CNT_WIDTH(8)
    ) u_a (
        .clock(clk), .reset(rstA), .start(startA),
        .busy(a_busy), .done(a_done),
        .img_addr(a_img_addr), .img_bit(a_img),
        .h_row(a_hrow), .h_col(a_hcol), .h_data(a_h),
        .sw_addr(a_swaddr), .sw_bit(a_sw),
        .c_row(a_crow), .c_col(a_ccol), .c_data(a_c),
        .pixel_id(a_pid), .pixel(a_pix), .Hvalue(a_hval),
        .HiddenSwitch(a_sw_o), .enable_hidden(a_enh),
        .enable_classi(a_enc), .Cvalue(a_cval),
        .hidden_id(a_hidid), .hidden_pixel(a_hpix),
        .hidden(a_hid_in), .spike(1'b1), .counts(a_counts)
    );

    // Instance B: same dimensions, 2 iterations.
    logic        b_busy, b_done, b_pix, b_sw_o, b_enh, b_enc, b_hpix;
    logic [1:0]  b_img_addr, b_hcol, b_swaddr, b_crow, b_hidid;
    logic [2:0]  b_hrow, b_pid;
    logic [0:0]  b_ccol;
    logic [11:0] b_hval, b_cval;
    logic [15:0] b_counts;
    logic [11:0] b_h = '0;

    always_ff @(posedge clk) begin
        b_h <= 12'(b_hrow) * 12'd16 + 12'(b_hcol);
    end

    rbm_sequencer #(
        .N_PIXEL(4), .N_HIDDEN(3), .N_CLASS(2),
        .W_WIDTH(12), .N_ITER(2), .CNT_WIDTH(8)
    ) u_b (
        .clock(clk), .reset(rstBC), .start(startBC),
        .busy(b_busy), .done(b_done),
        .img_addr(b_img_addr), .img_bit(1'b1),
        .h_row(b_hrow), .h_col(b_hcol), .h_data(b_h),
        .sw_addr(b_swaddr), .sw_bit(1'b0),
        .c_row(b_crow), .c_col(b_ccol), .c_data(12'd5),
        .pixel_id(b_pid), .pixel(b_pix), .Hvalue(b_hval),
        .HiddenSwitch(b_sw_o), .enable_hidden(b_enh),
        .enable_classi(b_enc), .Cvalue(b_cval),
        .hidden_id(b_hidid), .hidden_pixel(b_hpix),
        .hidden(1'b0), .spike(1'b1), .counts(b_counts)
    );

    // Instance C: 1 hidden neuron, 1-bit saturating counters.
    logic        c_busy, c_done, c_pix, c_sw_o, c_enh, c_enc, c_hpix;
    logic [0:0]  c_img_addr, c_hcol, c_swaddr, c_crow, c_ccol, c_hidid;
    logic [1:0]  c_hrow, c_pid;
    logic [11:0] c_hval, c_cval;
    logic [1:0]  c_counts;

    rbm_sequencer #(
        .N_PIXEL(2), .N_HIDDEN(1), .N_CLASS(2),
        .W_WIDTH(12), .N_ITER(2), .CNT_WIDTH(1)
    ) u_c (
        .clock(clk), .reset(rstBC), .start(startBC),
        .busy(c_busy), .done(c_done),
        .img_addr(c_img_addr), .img_bit(1'b1),
        .h_row(c_hrow), .h_col(c_hcol), .h_data(12'd0),
        .sw_addr(c_swaddr), .sw_bit(1'b0),
        .c_row(c_crow), .c_col(c_ccol), .c_data(12'd0),
        .pixel_id(c_pid), .pixel(c_pix), .Hvalue(c_hval),
        .HiddenSwitch(c_sw_o), .enable_hidden(c_enh),
        .enable_classi(c_enc), .Cvalue(c_cval),
        .hidden_id(c_hidid), .hidden_pixel(c_hpix),
        .hidden(1'b1), .spike(1'b1), .counts(c_counts)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full golden run of instance A, starting from IDLE.
    task automatic run_a();
        logic [11:0] ev;
        cyc    = 0;
        startA = 1'b1;
        chk("a_busy_c0", 32'(a_busy), 0);
        tick();
        startA = 1'b0;
        chk("a_busy_c1", 32'(a_busy), 1);
        chk("a_enh_c1", 32'(a_enh), 0);
        chk("a_hrow_c1", 32'(a_hrow), 0);
        for (int j = 0; j < 3; j++) begin
            for (int p = 0; p < 5; p++) begin
                tick();
                ev = (p == 4) ? 12'(100 + j) : 12'(p * 16 + j);
                chk("a_enh", 32'(a_enh), 1);
                chk("a_enc_h", 32'(a_enc), 0);
                chk("a_hval", 32'(a_hval), 32'(ev));
                chk("a_pixel", 32'(a_pix), 1);
                chk("a_hswitch", 32'(a_sw_o), 32'(j == 1));
                chk("a_pid", 32'(a_pid), 32'(p));
            end
        end
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                ev = (i == 3) ? 12'(200 + k) : 12'(i * 8 + k);
                chk("a_enc", 32'(a_enc), 1);
                chk("a_enh_c", 32'(a_enh), 0);
                chk("a_cval", 32'(a_cval), 32'(ev));
                chk("a_hpix", 32'(a_hpix), 32'(i == 1 || i == 3));
            end
        end
        tick();
        chk("a_done_c25", 32'(a_done), 1);
        chk("a_busy_c25", 32'(a_busy), 0);
        chk("a_enc_c25", 32'(a_enc), 0);
        tick();
        chk("a_done_c26", 32'(a_done), 0);
        chk("a_counts", 32'(a_counts), 32'h0101);
    endtask

    initial begin
        rstA    = 1'b0;
        rstBC   = 1'b0;
        startA  = 1'b0;
        startBC = 1'b0;
        tick();
        tick();
        chk("rst_a_busy", 32'(a_busy), 0);
        chk("rst_a_done", 32'(a_done), 0);
        chk("rst_a_enh", 32'(a_enh), 0);
        chk("rst_a_hval", 32'(a_hval), 0);
        chk("rst_a_cval", 32'(a_cval), 0);
        chk("rst_a_counts", 32'(a_counts), 0);
        chk("rst_c_counts", 32'(c_counts), 0);
        rstA  = 1'b1;
        rstBC = 1'b1;
        tick();
        tick();

        run_a();

        cyc    = 0;
        startA = 1'b1;
        tick();
        startA = 1'b0;
        goto(5);
        chk("mid_enh", 32'(a_enh), 1);
        rstA = 1'b0;
        tick();
        chk("mid_rst_enh", 32'(a_enh), 0);
        chk("mid_rst_busy", 32'(a_busy), 0);
        chk("mid_rst_hval", 32'(a_hval), 0);
        chk("mid_rst_pixel", 32'(a_pix), 0);
        chk("mid_rst_hrow", 32'(a_hrow), 0);
        tick();
        chk("mid_rst_done", 32'(a_done), 0);
        rstA = 1'b1;
        tick();
        run_a();

        cyc     = 0;
        startBC = 1'b1;
        tick();
        startBC = 1'b0;
        goto(5);
        chk("c_fwd_enc", 32'(c_enc), 1);
        chk("c_fwd_hpix", 32'(c_hpix), 1);
        goto(16);
        chk("c_done", 32'(c_done), 1);
        goto(17);
        chk("c_counts_sat", 32'(c_counts), 32'h3);
        goto(25);
        chk("b_iter2_enh", 32'(b_enh), 1);
        chk("b_iter2_enc", 32'(b_enc), 0);
        chk("b_iter2_hval", 32'(b_hval), 0);
        chk("b_no_done_25", 32'(b_done), 0);
        goto(26);
        chk("b_counts_it1", 32'(b_counts), 32'h0101);
        goto(47);
        chk("b_busy_47", 32'(b_busy), 1);
        goto(48);
        chk("b_done_48", 32'(b_done), 1);
        goto(49);
        chk("b_counts", 32'(b_counts), 32'h0202);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
